// File: rtl/branch_seq_ctrl_pkg.sv
// Shared definitions for the branch sequencer: condition codes, FSM
// state encoding and flush-counter width.
package branch_seq_ctrl_pkg;

  // Condition field values taken from instruction bits [11:8]
  localparam logic [3:0] COND_BEQ = 4'b0000;
  localparam logic [3:0] COND_BNE = 4'b0001;
  localparam logic [3:0] COND_BCS = 4'b0010;
  localparam logic [3:0] COND_BCC = 4'b0011;
  localparam logic [3:0] COND_BAL = 4'b1110;

  // Flush counter holds FLUSH_CYC, whose legal range is 1..7
  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_ACK   = 3'd2,
    ST_REDIR = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition decode: classifies the condition field
// and evaluates it against the committed carry/zero flags.
module branch_cond_eval
  import branch_seq_ctrl_pkg::*;
(
  input  logic [3:0] funct_i,
  input  logic       flag_c_i,
  input  logic       flag_z_i,
  output logic       taken_o,
  output logic       is_cond_o,
  output logic       is_bal_o
);

  // Decode condition class and taken/not-taken for the current flags
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    taken_o   = 1'b0;
    is_cond_o = 1'b0;
    is_bal_o  = 1'b0;
    case (funct_i)
      COND_BEQ: begin is_cond_o = 1'b1; taken_o = flag_z_i;  end
      COND_BNE: begin is_cond_o = 1'b1; taken_o = !flag_z_i; end
      COND_BCS: begin is_cond_o = 1'b1; taken_o = flag_c_i;  end
      COND_BCC: begin is_cond_o = 1'b1; taken_o = !flag_c_i; end
      COND_BAL: begin is_bal_o  = 1'b1; taken_o = 1'b1;      end
      default:  ; // unknown codes: not taken, never wait on flags
    endcase
  end

endmodule

// File: rtl/branch_seq_ctrl.sv
// Branch sequencer between ID and the PC register. Holds a decoded branch
// until flags are committed, evaluates it, redirects the PC and writes the
// link value on a taken branch, then flushes the younger pipe slots.
module branch_seq_ctrl
  import branch_seq_ctrl_pkg::*;
#(
  parameter int PC_W      = 16,
  parameter int OFF_W     = 8,
  parameter int FLUSH_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid_i,
  input  logic [3:0]       funct_i,
  input  logic [OFF_W-1:0] br_off_i,
  input  logic [PC_W-1:0]  br_pc_i,
  input  logic             flag_c_i,
  input  logic             flag_z_i,
  input  logic             flag_busy_i,
  output logic             br_ack_o,
  output logic             pc_load_o,
  output logic [PC_W-1:0]  pc_target_o,
  output logic             link_we_o,
  output logic [PC_W-1:0]  link_data_o,
  output logic             flush_o,
  output logic             stall_o
);

  logic taken, is_cond, is_bal;

  branch_cond_eval u_cond_eval (
    .funct_i   (funct_i),
    .flag_c_i  (flag_c_i),
    .flag_z_i  (flag_z_i),
    .taken_o   (taken),
    .is_cond_o (is_cond),
    .is_bal_o  (is_bal)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             eval_go;
  logic [PC_W-1:0]  link_d, target_d;
  logic [PC_W-1:0]  link_q, target_q;
  logic             br_ack_q, pc_load_q, link_we_q, flush_q, stall_q;

  // Link is the fall-through address; target adds the sign-extended offset.
  // Both wrap naturally at PC_W bits.
  assign link_d   = br_pc_i + PC_W'(1);
  assign target_d = link_d + {{(PC_W-OFF_W){br_off_i[OFF_W-1]}}, br_off_i};

  // Next-state, flush-counter and evaluation-strobe logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    eval_go = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (br_valid_i) begin
          if (is_cond && flag_busy_i) begin
            state_d = ST_WAIT;
          end else begin
            eval_go = 1'b1;
            state_d = taken ? ST_REDIR : ST_ACK;
          end
        end
      end
      ST_WAIT: begin
        if (!flag_busy_i) begin
          eval_go = 1'b1;
          state_d = taken ? ST_REDIR : ST_ACK;
        end
      end
      ST_ACK:   state_d = ST_IDLE;
      ST_REDIR: begin
        state_d = ST_FLUSH;
        cnt_d   = CNT_W'(FLUSH_CYC);
      end
      ST_FLUSH: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, counter and registered outputs; outputs decode the next state so
  // they are valid in the same cycle the FSM occupies that state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      br_ack_q  <= 1'b0;
      pc_load_q <= 1'b0;
      link_we_q <= 1'b0;
      flush_q   <= 1'b0;
      stall_q   <= 1'b0;
      // NOTE: the address registers are reset too, since they drive outputs that must read 0 after reset.
      target_q  <= '0;
      link_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      br_ack_q  <= (state_d == ST_ACK) || (state_d == ST_REDIR);
      pc_load_q <= (state_d == ST_REDIR);
      link_we_q <= (state_d == ST_REDIR) && is_bal;
      flush_q   <= (state_d == ST_FLUSH);
      stall_q   <= (state_d == ST_WAIT);
      if (eval_go) begin
        target_q <= target_d;
        link_q   <= link_d;
      end
    end
  end

  assign br_ack_o    = br_ack_q;
  assign pc_load_o   = pc_load_q;
  assign link_we_o   = link_we_q;
  assign flush_o     = flush_q;
  assign stall_o     = stall_q;
  assign pc_target_o = target_q;
  assign link_data_o = link_q;

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Self-checking bench for branch_seq_ctrl: directed scenarios plus
// randomized branches checked against a transaction-level reference model.
module tb_branch_seq_ctrl;

  localparam int FLUSH_CYC = 2;

  logic        clk, rst_n;
  logic        br_valid_i, flag_c_i, flag_z_i, flag_busy_i;
  logic [3:0]  funct_i;
  logic [7:0]  br_off_i;
  logic [15:0] br_pc_i;
  logic        br_ack_o, pc_load_o, link_we_o, flush_o, stall_o;
  logic [15:0] pc_target_o, link_data_o;

  int n_cmp = 0;
  int n_err = 0;

  branch_seq_ctrl #(.PC_W(16), .OFF_W(8), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .br_valid_i  (br_valid_i),
    .funct_i     (funct_i),
    .br_off_i    (br_off_i),
    .br_pc_i     (br_pc_i),
    .flag_c_i    (flag_c_i),
    .flag_z_i    (flag_z_i),
    .flag_busy_i (flag_busy_i),
    .br_ack_o    (br_ack_o),
    .pc_load_o   (pc_load_o),
    .pc_target_o (pc_target_o),
    .link_we_o   (link_we_o),
    .link_data_o (link_data_o),
    .flush_o     (flush_o),
    .stall_o     (stall_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (architectural rules) ----------------
  function automatic bit m_is_cond(input logic [3:0] f);
    return (f == 4'h0) || (f == 4'h1) || (f == 4'h2) || (f == 4'h3);
  endfunction

  function automatic bit m_taken(input logic [3:0] f, input bit c, input bit z);
    if (f == 4'h0) return z;
    if (f == 4'h1) return !z;
    if (f == 4'h2) return c;
    if (f == 4'h3) return !c;
    if (f == 4'hE) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] m_wrap(input int v);
    int r;
    r = ((v % 65536) + 65536) % 65536;
    return 16'(r);
  endfunction

  function automatic logic [15:0] m_target(input logic [15:0] pc, input logic [7:0] off);
    int so;
    so = off[7] ? int'(off) - 256 : int'(off);
    return m_wrap(int'(pc) + 1 + so);
  endfunction

  // Outputs packed for reset checks: {ack, load, link_we, flush, stall, target, link}
  function automatic logic [36:0] all_outs();
    return {br_ack_o, pc_load_o, link_we_o, flush_o, stall_o, pc_target_o, link_data_o};
  endfunction

  task automatic idle_inputs();
    br_valid_i  = 1'b0;
    funct_i     = 4'h0;
    br_off_i    = 8'h00;
    br_pc_i     = 16'h0000;
    flag_c_i    = 1'b0;
    flag_z_i    = 1'b0;
    flag_busy_i = 1'b0;
  endtask

  // One branch: flag_busy high for nb edges; cv/zv give the flags per edge.
  task automatic run_txn(input string tag, input logic [3:0] f, input logic [15:0] pc,
                         input logic [7:0] off, input int nb, input logic [4:0] cv,
                         input logic [4:0] zv, output logic [15:0] got_tgt,
                         output logic [15:0] got_lnk);
    int e, ack_at, n_stall, n_ack, n_load, n_link, n_flush, idx;
    bit tk, bal;
    e       = m_is_cond(f) ? nb : 0;
    bal     = (f == 4'hE);
    tk      = m_taken(f, cv[e], zv[e]);
    ack_at  = -1;
    n_stall = 0; n_ack = 0; n_load = 0; n_link = 0; n_flush = 0;
    got_tgt = '0; got_lnk = '0;
    br_valid_i = 1'b1; funct_i = f; br_pc_i = pc; br_off_i = off;
    flag_c_i = cv[0]; flag_z_i = zv[0]; flag_busy_i = (nb > 0);
    for (int i = 0; i < e + FLUSH_CYC + 3; i++) begin
      @(posedge clk); #1;
      if (stall_o)   n_stall++;
      if (pc_load_o) n_load++;
      if (link_we_o) n_link++;
      if (flush_o)   n_flush++;
      if (br_ack_o) begin
        n_ack++;
        if (ack_at < 0) begin
          ack_at  = i;
          got_tgt = pc_target_o;
          got_lnk = link_data_o;
        end
        br_valid_i = 1'b0;
      end
      idx = (i + 1 > 4) ? 4 : i + 1;
      flag_busy_i = (i + 1 < nb);
      flag_c_i    = cv[idx];
      flag_z_i    = zv[idx];
    end
    idle_inputs();
    check({tag, "_stall_cycles"}, n_stall, e);
    check({tag, "_ack_count"},    n_ack, 1);
    check({tag, "_ack_cycle"},    ack_at, e);
    check({tag, "_pc_load"},      n_load, tk ? 1 : 0);
    check({tag, "_link_we"},      n_link, (tk && bal) ? 1 : 0);
    check({tag, "_flush_cycles"}, n_flush, tk ? FLUSH_CYC : 0);
    check({tag, "_target"},       got_tgt, m_target(pc, off));
    check({tag, "_link_data"},    got_lnk, m_wrap(int'(pc) + 1));
  endtask

  // After a mid-sequence reset: nothing may pulse over a few cycles
  task automatic check_quiet(input string tag);
    int n_act;
    n_act = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (br_ack_o || pc_load_o || flush_o || stall_o || link_we_o) n_act++;
    end
    check({tag, "_quiet_after_reset"}, n_act, 0);
  endtask

  logic [15:0] tgt, lnk;
  logic [3:0]  others [$] = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hF};

  initial begin
    int ack_at;
    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check("reset_outputs", all_outs(), '0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", all_outs(), '0);

    // 1. BEQ taken, no wait
    run_txn("t1_beq", 4'h0, 16'h0010, 8'h05, 0, 5'b00000, 5'b11111, tgt, lnk);
    check("t1_target_const", tgt, 16'h0016);
    // 2. BNE with Z=1: ack path only
    run_txn("t2_bne", 4'h1, 16'h0100, 8'h07, 0, 5'b00000, 5'b11111, tgt, lnk);
    // 3. BCC waits 3 cycles, C=0 at release (C=1 earlier must be ignored)
    run_txn("t3_bcc", 4'h3, 16'h0040, 8'h10, 3, 5'b00111, 5'b00000, tgt, lnk);
    // 4. BAL with flag_busy high: no stall, wrap, link
    run_txn("t4_bal", 4'hE, 16'hFFFE, 8'h01, 3, 5'b00000, 5'b00000, tgt, lnk);
    check("t4_target_wrap", tgt, 16'h0000);
    check("t4_link_const",  lnk, 16'hFFFF);

    // 5. BCS backward, then a new branch during FLUSH waits for IDLE
    br_valid_i = 1'b1; funct_i = 4'h2; br_pc_i = 16'h0003; br_off_i = 8'hF0;
    flag_c_i = 1'b1; flag_z_i = 1'b0; flag_busy_i = 1'b0;
    ack_at = -1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        check("t5_ack", br_ack_o, 1'b1);
        check("t5_target", pc_target_o, 16'hFFF4);
        br_valid_i = 1'b0;
      end else begin
        if (i == 1) begin
          check("t5_flush", flush_o, 1'b1);
          br_valid_i = 1'b1; funct_i = 4'h1; flag_z_i = 1'b1; br_pc_i = 16'h0200;
        end
        if (br_ack_o && ack_at < 0) begin
          ack_at = i;
          br_valid_i = 1'b0;
        end
      end
    end
    idle_inputs();
    check("t5_late_ack_cycle", ack_at, FLUSH_CYC + 2);

    // 6a. Reset while in WAIT
    br_valid_i = 1'b1; funct_i = 4'h0; flag_z_i = 1'b1; flag_busy_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6a_stall_before", stall_o, 1'b1);
    rst_n = 1'b0;
    #1 check("t6a_async_outputs", all_outs(), '0);
    idle_inputs();
    #2 rst_n = 1'b1;
    check_quiet("t6a");
    run_txn("t6a_post", 4'h0, 16'h1234, 8'h02, 0, 5'b00000, 5'b11111, tgt, lnk);

    // 6b. Reset while in FLUSH
    br_valid_i = 1'b1; funct_i = 4'hE; br_pc_i = 16'h0500; br_off_i = 8'h20;
    @(posedge clk); #1;
    br_valid_i = 1'b0;
    @(posedge clk); #1;
    check("t6b_flush_before", flush_o, 1'b1);
    rst_n = 1'b0;
    #1 check("t6b_async_outputs", all_outs(), '0);
    idle_inputs();
    #2 rst_n = 1'b1;
    check_quiet("t6b");

    // Randomized branches against the model
    for (int n = 0; n < 40; n++) begin
      logic [3:0] f;
      int sel;
      sel = $urandom_range(0, 6);
      if (sel <= 3)      f = 4'(sel);
      else if (sel == 4) f = 4'hE;
      else               f = others[$urandom_range(0, 10)];
      run_txn($sformatf("rnd%0d", n), f, 16'($urandom), 8'($urandom),
              $urandom_range(0, 3), 5'($urandom), 5'($urandom), tgt, lnk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
